// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO on the CPU data bus.
// TXDATA (offset 0) queues a byte; STATUS (offset 4) reports FIFO/FSM state
// and lets software clear the sticky overflow flag.
module uart_tx_mmio #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state;
  logic [7:0]       shift;
  logic [CNT_W-1:0] baud;
  logic [2:0]       bit_idx;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;

  logic sel;
  logic wr_tx;
  logic wr_st;
  logic full;
  logic empty;
  logic busy;
  logic push;
  logic pop;
  logic [31:0] status;
  logic unused_bits;

  // Address decode and FIFO handshakes; full is judged before any same-edge pop.
  assign sel   = (addr[31:3] == BASE_ADDR[31:3]);
  assign wr_tx = we && sel && !addr[2];
  assign wr_st = we && sel && addr[2];
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign busy  = (state != S_IDLE);
  assign push  = wr_tx && !full;
  assign pop   = (state == S_IDLE) && !empty;

  assign status = {16'h0000, 8'(count), 4'h0, overflow, busy, empty, full};
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  // Zero-latency read path to match the CPU load timing.
  always_comb begin
    rdata = '0;
    if (sel && addr[2]) rdata = status;
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
      if (wr_tx && full)             overflow <= 1'b1;
      else if (wr_st && wdata[3])    overflow <= 1'b0;
    end
  end

  // Serializer FSM with registered tx; one IDLE cycle separates frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= '0;
            tx    <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (baud == CNT_LAST) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            baud <= baud + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (baud == CNT_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + CNT_W'(1);
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (baud == CNT_LAST) begin
            baud  <= '0;
            state <= S_IDLE;
          end else begin
            baud <= baud + CNT_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=8.
module tb_uart_tx_mmio;

  localparam int unsigned CD   = 4;
  localparam int unsigned FD   = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int unsigned FRAME_PERIOD = 10 * CD + 1;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;

  int errors = 0;
  int checks = 0;

  uart_tx_mmio #(
    .CLK_DIV   (CD),
    .FIFO_DEPTH(FD),
    .BASE_ADDR (BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .tx   (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // Independent serial receiver: samples tx mid-bit on falling edges.
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         stop_err = 0;
  int         cyc = 0;
  bit         mon_active = 0;
  int         mon_cnt = 0;
  int         mon_start = 0;
  logic [7:0] mon_byte = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1;
        mon_cnt    = 0;
        mon_start  = cyc;
        mon_byte   = '0;
      end
    end else begin
      mon_cnt = mon_cnt + 1;
      if (mon_cnt >= int'(CD) + 1 && mon_cnt <= int'(9 * CD) - 3 &&
          ((mon_cnt - int'(CD) - 1) % int'(CD)) == 0)
        mon_byte[(mon_cnt - int'(CD) - 1) / int'(CD)] = tx;
      if (mon_cnt == int'(9 * CD) + 1) begin
        if (tx !== 1'b1) stop_err = stop_err + 1;
        rx_q.push_back(mon_byte);
        start_q.push_back(mon_start);
        mon_active = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One bus write on the next rising edge; returns 1 time unit after that edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  typedef struct {
    string       name;
    logic        do_wr;
    logic [31:0] waddr;
    logic [31:0] wdat;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    int          j;
    int          bad;
    bit          done;
    logic        exp_tx;

    reset = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;

    vecs[0] = '{"idle_status",      1'b0, 32'h0,          32'h0,         BASE + 32'd4, 32'h0000_0002};
    vecs[1] = '{"idle_txdata_rd",   1'b0, 32'h0,          32'h0,         BASE,         32'h0000_0000};
    vecs[2] = '{"dec_base8_rd",     1'b1, BASE + 32'd8,   32'h55,        BASE + 32'd8, 32'h0000_0000};
    vecs[3] = '{"dec_below_rd",     1'b1, BASE - 32'd4,   32'h55,        BASE - 32'd4, 32'h0000_0000};
    vecs[4] = '{"dec_no_push",      1'b0, 32'h0,          32'h0,         BASE + 32'd4, 32'h0000_0002};
    vecs[5] = '{"dec_base7_status", 1'b0, 32'h0,          32'h0,         BASE + 32'd7, 32'h0000_0002};
    vecs[6] = '{"dec_base5_status", 1'b0, 32'h0,          32'h0,         BASE + 32'd5, 32'h0000_0002};
    vecs[7] = '{"st_clr_idle",      1'b1, BASE + 32'd4,   32'h8,         BASE + 32'd4, 32'h0000_0002};
    vecs[8] = '{"st_readonly",      1'b1, BASE + 32'd6,   32'hFFFF_FFF7, BASE + 32'd4, 32'h0000_0002};

    // Asynchronous reset asserted between clock edges.
    #2 reset = 1'b1;
    #1;
    check("reset_tx", 32'(tx), 32'h1);
    read_reg(BASE + 32'd4, r);
    check("reset_status", r, 32'h0000_0002);
    read_reg(BASE, r);
    check("reset_txdata", r, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Register/decode vectors with the transmitter idle.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].waddr, vecs[i].wdat);
      else begin
        @(posedge clk);
        #1;
      end
      read_reg(vecs[i].raddr, r);
      check(vecs[i].name, r, vecs[i].exp_rdata);
      check({vecs[i].name, "_tx"}, 32'(tx), 32'h1);
    end

    // Single byte 0xA5: exact bit waveform and busy window.
    rx_q.delete();
    start_q.delete();
    b = 8'hA5;
    bus_write(BASE, 32'hFFFF_FFA5);
    read_reg(BASE + 32'd4, r);
    check("sb_queued_status", r, 32'h0000_0100);
    check("sb_tx_before_pop", 32'(tx), 32'h1);
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk);
      #1;
      j = (k - 1) / int'(CD);
      if (j == 0)      exp_tx = 1'b0;
      else if (j <= 8) exp_tx = b[j - 1];
      else             exp_tx = 1'b1;
      check($sformatf("sb_tx_k%0d", k), 32'(tx), 32'(exp_tx));
      check($sformatf("sb_busy_k%0d", k), 32'(rdata[2]), (k <= 40) ? 32'h1 : 32'h0);
    end
    read_reg(BASE + 32'd4, r);
    check("sb_status_done", r, 32'h0000_0002);
    check("sb_rx_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("sb_rx_byte", 32'(rx_q[0]), 32'hA5);

    // Fill to full, overflow on the tenth write, then clear overflow.
    rx_q.delete();
    start_q.delete();
    for (int i = 0; i < 10; i++) begin
      bus_write(BASE, 32'(i));
      if (i == 8) begin
        read_reg(BASE + 32'd4, r);
        check("fill_9th_status", r, 32'h0000_0805);
      end
      if (i == 9) begin
        read_reg(BASE + 32'd4, r);
        check("fill_10th_status", r, 32'h0000_080D);
      end
    end
    bus_write(BASE + 32'd4, 32'h8);
    read_reg(BASE + 32'd4, r);
    check("ovf_clear_status", r, 32'h0000_0805);

    done = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(posedge clk);
      #1;
      if (rdata == 32'h0000_0002) done = 1;
    end
    check("fill_drained", 32'(done), 32'h1);
    repeat (60) @(posedge clk);
    #1;
    check("fill_rx_count", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      check($sformatf("fill_rx_byte%0d", i), 32'(rx_q[i]), 32'(i));
    for (int i = 1; i < start_q.size(); i++)
      check($sformatf("fill_period%0d", i), 32'(start_q[i] - start_q[i - 1]), 32'(FRAME_PERIOD));
    check("fill_stop_bits", 32'(stop_err), 32'h0);

    // Reset during bit 3 of 0xA5 with three more bytes queued.
    rx_q.delete();
    start_q.delete();
    bus_write(BASE, 32'hA5);
    bus_write(BASE, 32'h11);
    bus_write(BASE, 32'h22);
    bus_write(BASE, 32'h33);
    read_reg(BASE + 32'd4, r);
    check("mf_queued_status", r, 32'h0000_0304);
    repeat (14) @(posedge clk);
    #1;
    check("mf_bit3_low", 32'(tx), 32'h0);
    #2 reset = 1'b1;
    #1;
    check("mf_reset_tx", 32'(tx), 32'h1);
    read_reg(BASE + 32'd4, r);
    check("mf_reset_status", r, 32'h0000_0002);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    read_reg(BASE + 32'd4, r);
    check("mf_release_status", r, 32'h0000_0002);
    bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) bad = bad + 1;
    end
    check("mf_quiet_tx", 32'(bad), 32'h0);
    check("mf_no_frames", 32'(rx_q.size()), 32'h0);
    read_reg(BASE + 32'd4, r);
    check("mf_final_status", r, 32'h0000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
